// File: rtl/registro_de_estado_pkg.sv
// Shared definitions for the "110" detector state register: state codes and default widths.
package registro_de_estado_pkg;

   localparam int unsigned CNT_W_DEF = 8;

   // {y1,y2}: A idle, B saw "1", C saw "11", D saw "110"
   typedef enum logic [1:0] {
      ST_A = 2'b00,
      ST_B = 2'b01,
      ST_C = 2'b10,
      ST_D = 2'b11
   } estado_t;

endpackage

// File: rtl/registro_de_estado_contador_saturado.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module contador_saturado
   import registro_de_estado_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] q_d;

   // clear wins over a same-cycle increment
   always_comb begin
      q_d = q;
      if (clr) begin
         q_d = '0;
      end else if (inc && (q != CNT_MAX)) begin
         q_d = q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else begin
         q <= q_d;
      end
   end

endmodule

// File: rtl/registro_de_estado.sv
// State register and Mealy output stage of the "110" serial detector; the next-state
// logic sits outside and closes the loop through w/y1/y2 -> Yin1/Yin2.
module registro_de_estado
   import registro_de_estado_pkg::*;
#(
   parameter int unsigned CNT_W  = CNT_W_DEF,
   parameter estado_t     RST_ST = ST_A
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             w_in,
   input  logic             Yin1,
   input  logic             Yin2,
   output logic             w,
   output logic             y1,
   output logic             y2,
   output logic             z,
   output logic [CNT_W-1:0] det_count
);

   logic    en_q;
   logic    w_d;
   logic    en_d;
   estado_t estado_q;
   estado_t estado_d;

   // next values for the input stage and the state; the state only moves on a valid bit
   always_comb begin
      w_d      = w_in;
      en_d     = en;
      estado_d = estado_q;
      if (clr) begin
         w_d      = 1'b0;
         en_d     = 1'b0;
         estado_d = RST_ST;
      end else if (en_q) begin
         estado_d = estado_t'({Yin1, Yin2});
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w        <= 1'b0;
         en_q     <= 1'b0;
         estado_q <= RST_ST;
      end else begin
         w        <= w_d;
         en_q     <= en_d;
         estado_q <= estado_d;
      end
   end

   assign y1 = estado_q[1];
   assign y2 = estado_q[0];

   // C->D transition pending: valid "0" arriving while in C
   assign z = en_q & y1 & ~y2 & ~w;

   contador_saturado #(
      .CNT_W (CNT_W)
   ) u_det_count (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .inc   (z),
      .q     (det_count)
   );

endmodule

// File: tb/tb_registro_de_estado.sv
// Closed-loop bench for registro_de_estado: two instances (8-bit and 2-bit counters) fed
// by the reference next-state table, checked against a pattern-prefix model.
module tb_registro_de_estado;

   logic clk;
   logic reset;
   logic clr;
   logic en;
   logic w_in;

   logic       w_a, y1_a, y2_a, z_a;
   logic       w_b, y1_b, y2_b, z_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;
   logic [1:0] ns_a, ns_b;

   int checks = 0;
   int passed = 0;

   // behavioural model state
   string pattern;
   int    prog;
   bit    pend_valid;
   bit    pend_bit;
   int    exp_cnt_a;
   int    exp_cnt_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // next-state logic from the reference transition table
   function automatic logic [1:0] nsl(input logic [1:0] y, input logic b);
      case (y)
         2'b00:   nsl = b ? 2'b01 : 2'b00;
         2'b01:   nsl = b ? 2'b10 : 2'b00;
         2'b10:   nsl = b ? 2'b00 : 2'b11;
         default: nsl = 2'b00;
      endcase
   endfunction

   always_comb ns_a = nsl({y1_a, y2_a}, w_a);
   always_comb ns_b = nsl({y1_b, y2_b}, w_b);

   registro_de_estado #(.CNT_W(8)) dut_a (
      .clk (clk), .reset (reset), .clr (clr), .en (en), .w_in (w_in),
      .Yin1 (ns_a[1]), .Yin2 (ns_a[0]),
      .w (w_a), .y1 (y1_a), .y2 (y2_a), .z (z_a), .det_count (cnt_a)
   );

   registro_de_estado #(.CNT_W(2)) dut_b (
      .clk (clk), .reset (reset), .clr (clr), .en (en), .w_in (w_in),
      .Yin1 (ns_b[1]), .Yin2 (ns_b[0]),
      .w (w_b), .y1 (y1_b), .y2 (y2_b), .z (z_b), .det_count (cnt_b)
   );

   function automatic byte bitchar(input bit b);
      return b ? 8'h31 : 8'h30;
   endfunction

   // prog = length of "110" prefix matched; a full match is consumed on the next bit
   function automatic int advance(input int p, input bit b);
      if (p == 3) return 0;
      if (pattern.getc(p) == bitchar(b)) return p + 1;
      return 0;
   endfunction

   function automatic bit exp_z();
      return pend_valid && (prog == 2) && (pattern.getc(2) == bitchar(pend_bit));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      prog       = 0;
      pend_valid = 1'b0;
      pend_bit   = 1'b0;
      exp_cnt_a  = 0;
      exp_cnt_b  = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".w_a"},   32'(w_a),            32'(pend_bit));
      chk({tag, ".w_b"},   32'(w_b),            32'(pend_bit));
      chk({tag, ".y_a"},   32'({y1_a, y2_a}),   32'(prog));
      chk({tag, ".y_b"},   32'({y1_b, y2_b}),   32'(prog));
      chk({tag, ".z_a"},   32'(z_a),            32'(exp_z()));
      chk({tag, ".z_b"},   32'(z_b),            32'(exp_z()));
      chk({tag, ".cnt_a"}, 32'(cnt_a),          32'(exp_cnt_a));
      chk({tag, ".cnt_b"}, 32'(cnt_b),          32'(exp_cnt_b));
   endtask

   // one clock: drive at negedge, check z before the edge, update model, check after
   task automatic step(input string tag, input bit e, input bit b, input bit c);
      bit det;
      @(negedge clk);
      en   = e;
      w_in = b;
      clr  = c;
      #1;
      chk({tag, ".zpre_a"}, 32'(z_a), 32'(exp_z()));
      chk({tag, ".zpre_b"}, 32'(z_b), 32'(exp_z()));
      det = exp_z();
      @(posedge clk);
      #1;
      if (c) begin
         prog       = 0;
         pend_valid = 1'b0;
         pend_bit   = 1'b0;
         exp_cnt_a  = 0;
         exp_cnt_b  = 0;
      end else begin
         if (pend_valid) prog = advance(prog, pend_bit);
         if (det) begin
            exp_cnt_a = (exp_cnt_a < 255) ? exp_cnt_a + 1 : 255;
            exp_cnt_b = (exp_cnt_b < 3)   ? exp_cnt_b + 1 : 3;
         end
         pend_valid = e;
         pend_bit   = b;
      end
      check_all(tag);
   endtask

   // reset pulse raised mid-cycle, checked before any clock edge
   task automatic mid_reset(input string tag);
      @(negedge clk);
      en  = 1'b0;
      clr = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_all({tag, ".rel"});
   endtask

   initial begin
      pattern = "110";
      reset   = 1'b0;
      clr     = 1'b0;
      en      = 1'b0;
      w_in    = 1'b0;
      model_reset();

      // asynchronous reset from power-up
      #2;
      reset = 1'b1;
      #1;
      check_all("rst0");
      @(negedge clk);
      reset = 1'b0;

      // plain "110"
      step("t2_1", 1, 1, 0);
      step("t2_2", 1, 1, 0);
      step("t2_3", 1, 0, 0);
      step("t2_4", 0, 0, 0);
      step("t2_5", 0, 0, 0);

      // "1110": C-1->A, no detection
      mid_reset("t3_rst");
      step("t3_1", 1, 1, 0);
      step("t3_2", 1, 1, 0);
      step("t3_3", 1, 1, 0);
      step("t3_4", 1, 0, 0);
      step("t3_5", 0, 0, 0);
      step("t3_6", 0, 0, 0);

      // bubbles inside the sequence
      mid_reset("t4_rst");
      step("t4_1", 1, 1, 0);
      step("t4_g1", 0, 1, 0);
      step("t4_g2", 0, 1, 0);
      step("t4_g3", 0, 1, 0);
      step("t4_2", 1, 1, 0);
      step("t4_3", 1, 0, 0);
      step("t4_4", 0, 0, 0);
      step("t4_5", 0, 0, 0);

      // five back-to-back patterns: 2-bit counter saturates
      mid_reset("t5_rst");
      for (int i = 0; i < 5; i++) begin
         step("t5_1", 1, 1, 0);
         step("t5_1", 1, 1, 0);
         step("t5_0", 1, 0, 0);
      end
      step("t5_e", 0, 0, 0);
      step("t5_e", 0, 0, 0);

      // clear coincident with a detection
      step("t6_1", 1, 1, 0);
      step("t6_2", 1, 1, 0);
      step("t6_3", 1, 0, 0);
      step("t6_clr", 0, 0, 1);
      step("t6_4", 0, 0, 0);

      // async reset while in C, then a "0" must not detect
      step("t6b_1", 1, 1, 0);
      step("t6b_2", 1, 1, 0);
      step("t6b_3", 0, 0, 0);
      chk("t6b_inC", 32'({y1_a, y2_a}), 32'(2));
      mid_reset("t6b_rst");
      step("t6b_4", 1, 0, 0);
      step("t6b_5", 0, 0, 0);
      step("t6b_6", 0, 0, 0);

      // randomized traffic with occasional clears and resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            mid_reset("rnd_rst");
         end else begin
            step("rnd",
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 59) == 0));
         end
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
